// File: rtl/lfsr_stim_bank.sv
// lfsr_stim_bank: NUM_CH parallel Galois LFSR stimulus channels for random
// out-of-context wrappers, with FREE / HOLD / handshaked STEP modes.
// Optional MISR (macro STIM_BANK_MISR_EN) folds wide DUT outputs into one
// signature so their driving logic survives synthesis. With the macro
// undefined the signature is tied to zero and obs_in is ignored.

// One stimulus channel: a WIDTH-bit Galois LFSR with seed reload.
module lfsr_stim_ch #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(32'h00400007),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             reseed,
    output logic [WIDTH-1:0] q
);

    // Galois step: shift left, fold the mask in when the msb falls out
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return s[WIDTH-1] ? ((s << 1) ^ POLY) : (s << 1);
    endfunction

    // Seed on reset or reseed (reseed wins over advance), else step on adv
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= SEED;
        else if (reseed)
            q <= SEED;
        else if (adv)
            q <= lfsr_next(q);
    end

endmodule

module lfsr_stim_bank #(
    parameter int               NUM_CH    = 4,
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(32'h00400007),
    parameter logic [63:0]      SEED_BASE = 64'd5,
    parameter logic [63:0]      SEED_STEP = 64'd2,
    parameter int               OBS_W     = 128,
    parameter int               MISR_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic                    reseed,
    input  logic                    step_req,
    output logic                    step_ack,
    output logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic [15:0]             adv_cnt,
    input  logic [OBS_W-1:0]        obs_in,
    output logic [MISR_W-1:0]       signature
);

    localparam logic [1:0] M_FREE = 2'b00;
    localparam logic [1:0] M_STEP = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_ACK      = 2'b01,
        S_WAIT_LOW = 2'b10
    } step_state_t;

    step_state_t                    state;
    logic [NUM_CH-1:0][WIDTH-1:0]   ch_q;
    logic                           run_free;
    logic                           run_step;
    logic                           advance;

    // Advances only originate from IDLE; ACK / WAIT_LOW block FREE stepping
    // so a handshake never overlaps a free-running burst.
    assign run_free = (state == S_IDLE) && enable && (mode == M_FREE);
    assign run_step = (state == S_IDLE) && enable && (mode == M_STEP) && step_req;
    // A coincident reseed suppresses the step, but the FSM still consumes it
    assign advance  = (run_free || run_step) && !reseed;

    // Per-channel LFSRs; seeds are fixed at elaboration, zero forced to one
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [63:0]      SEED_RAW = SEED_BASE + 64'(i) * SEED_STEP;
        localparam logic [WIDTH-1:0] SEED_TR  = WIDTH'(SEED_RAW);
        localparam logic [WIDTH-1:0] SEED_CH  = (SEED_TR == '0) ? WIDTH'(1) : SEED_TR;

        lfsr_stim_ch #(
            .WIDTH (WIDTH),
            .POLY  (POLY),
            .SEED  (SEED_CH)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .adv    (advance),
            .reseed (reseed),
            .q      (ch_q[i])
        );
    end

    assign ch_data = ch_q;

    // Advance counter: cleared by reseed, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            adv_cnt <= '0;
        else if (reseed)
            adv_cnt <= '0;
        else if (advance)
            adv_cnt <= adv_cnt + 16'd1;
    end

    // STEP handshake FSM with registered one-cycle acknowledge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            step_ack <= 1'b0;
        end else begin
            step_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run_step) begin
                        state    <= S_ACK;
                        step_ack <= 1'b1;
                    end
                end
                S_ACK: begin
                    state <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    // Release on request drop, or when STEP mode is abandoned
                    if (!step_req || (mode != M_STEP))
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STIM_BANK_MISR_EN
    localparam int                NUM_SLICE = OBS_W / MISR_W;
    localparam logic [MISR_W-1:0] MISR_POLY = MISR_W'(POLY);

    logic [MISR_W-1:0] obs_fold;

    // XOR all MISR_W-wide slices of the observed bus together
    always_comb begin
        obs_fold = '0;
        for (int k = 0; k < NUM_SLICE; k++)
            obs_fold = obs_fold ^ obs_in[k*MISR_W +: MISR_W];
    end

    // Signature register: Galois step on the low POLY bits, then fold in obs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            signature <= '0;
        else if (enable)
            signature <= (signature[MISR_W-1] ? ((signature << 1) ^ MISR_POLY)
                                              : (signature << 1)) ^ obs_fold;
    end
`else
    logic unused_obs;

    // No compression: observed bus is intentionally dropped
    assign unused_obs = ^obs_in;
    assign signature  = '0;
`endif

endmodule

// File: tb/tb_lfsr_stim_bank.sv
// Directed bench for lfsr_stim_bank: default seeds, high-bit and zero seed
// variants, FREE/HOLD/STEP modes, reseed, async reset mid-handshake, adv_cnt
// wrap and the optional MISR signature.
module tb_lfsr_stim_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [1:0]   mode;
    logic         reseed;
    logic         step_req;
    logic [127:0] obs_in;

    logic         ack_a, ack_h, ack_z;
    logic [127:0] ch_a, ch_h, ch_z;
    logic [15:0]  cnt_a, cnt_h, cnt_z;
    logic [31:0]  sig_a, sig_h, sig_z;

    int n_cmp = 0;
    int n_err = 0;
    bit misr_on;

    always #5 clk = ~clk;

    lfsr_stim_bank u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .reseed(reseed),
        .step_req(step_req), .step_ack(ack_a), .ch_data(ch_a), .adv_cnt(cnt_a),
        .obs_in(obs_in), .signature(sig_a)
    );

    lfsr_stim_bank #(.SEED_BASE(64'h8000_0000), .SEED_STEP(64'd0)) u_hi (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .reseed(reseed),
        .step_req(step_req), .step_ack(ack_h), .ch_data(ch_h), .adv_cnt(cnt_h),
        .obs_in(obs_in), .signature(sig_h)
    );

    lfsr_stim_bank #(.SEED_BASE(64'd0), .SEED_STEP(64'd0)) u_zero (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .reseed(reseed),
        .step_req(step_req), .step_ack(ack_z), .ch_data(ch_z), .adv_cnt(cnt_z),
        .obs_in(obs_in), .signature(sig_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
`ifdef STIM_BANK_MISR_EN
        misr_on = 1'b1;
`else
        misr_on = 1'b0;
`endif
        reset = 1'b0; enable = 1'b0; mode = 2'b01; reseed = 1'b0;
        step_req = 1'b0; obs_in = '0;
        tick();

        // Reset values
        check("rst_ch0", ch_a[31:0], 32'h5);
        check("rst_ch1", ch_a[63:32], 32'h7);
        check("rst_ch2", ch_a[95:64], 32'h9);
        check("rst_ch3", ch_a[127:96], 32'hB);
        check("rst_cnt", 32'(cnt_a), 32'h0);
        check("rst_ack", 32'(ack_a), 32'h0);
        check("rst_sig", sig_a, 32'h0);
        check("hi_rst_ch0", ch_h[31:0], 32'h8000_0000);
        check("zero_rst_ch0", ch_z[31:0], 32'h1);
        check("zero_rst_ch3", ch_z[127:96], 32'h1);

        // FREE run
        reset = 1'b1; enable = 1'b1; mode = 2'b00;
        tick();
        check("free1_ch0", ch_a[31:0], 32'hA);
        check("free1_ch1", ch_a[63:32], 32'hE);
        check("free1_cnt", 32'(cnt_a), 32'h1);
        check("hi_ch0", ch_h[31:0], 32'h0040_0007);
        check("hi_ch3", ch_h[127:96], 32'h0040_0007);
        check("zero_free1_ch0", ch_z[31:0], 32'h2);
        tick();
        check("free2_ch0", ch_a[31:0], 32'h14);
        check("free2_ch1", ch_a[63:32], 32'h1C);
        check("free2_cnt", 32'(cnt_a), 32'h2);
        check("sig_obs0", sig_a, 32'h0);

        // HOLD and mode 11
        mode = 2'b01;
        tick(); tick();
        check("hold_ch0", ch_a[31:0], 32'h14);
        check("hold_cnt", 32'(cnt_a), 32'h2);
        mode = 2'b11;
        tick();
        check("m11_ch0", ch_a[31:0], 32'h14);
        check("m11_cnt", 32'(cnt_a), 32'h2);

        // Three more FREE advances, then reseed
        mode = 2'b00;
        tick(); tick(); tick();
        check("free5_ch0", ch_a[31:0], 32'hA0);
        check("free5_cnt", 32'(cnt_a), 32'h5);
        reseed = 1'b1;
        tick();
        check("reseed_ch0", ch_a[31:0], 32'h5);
        check("reseed_ch1", ch_a[63:32], 32'h7);
        check("reseed_cnt", 32'(cnt_a), 32'h0);
        reseed = 1'b0;
        tick();
        check("post_reseed_ch0", ch_a[31:0], 32'hA);
        check("post_reseed_cnt", 32'(cnt_a), 32'h1);
        enable = 1'b0;
        tick();
        check("dis_ch0", ch_a[31:0], 32'hA);
        check("dis_cnt", 32'(cnt_a), 32'h1);

        // STEP handshake from reset with a held request
        reset = 1'b0; mode = 2'b10; step_req = 1'b1; enable = 1'b1;
        tick();
        check("step_rst_ch0", ch_a[31:0], 32'h5);
        reset = 1'b1;
        tick();
        check("step1_ch0", ch_a[31:0], 32'hA);
        check("step1_ack", 32'(ack_a), 32'h1);
        check("step1_cnt", 32'(cnt_a), 32'h1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("held_ack", 32'(ack_a), 32'h0);
            check("held_ch0", ch_a[31:0], 32'hA);
        end
        check("held_cnt", 32'(cnt_a), 32'h1);
        step_req = 1'b0;
        tick();
        check("drop_ch0", ch_a[31:0], 32'hA);
        step_req = 1'b1;
        tick();
        check("step2_ch0", ch_a[31:0], 32'h14);
        check("step2_ack", 32'(ack_a), 32'h1);
        check("step2_cnt", 32'(cnt_a), 32'h2);
        tick();
        check("step2_ack_low", 32'(ack_a), 32'h0);
        // Leave STEP while in WAIT_LOW: that edge only returns to IDLE
        mode = 2'b00;
        tick();
        check("exit_ch0", ch_a[31:0], 32'h14);
        check("exit_cnt", 32'(cnt_a), 32'h2);
        tick();
        check("exit_free_ch0", ch_a[31:0], 32'h28);

        // Async reset in the ACK cycle
        reset = 1'b0; mode = 2'b10; step_req = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("mid_ack_hi", 32'(ack_a), 32'h1);
        reset = 1'b0;
        #1;
        check("mid_ack_drop", 32'(ack_a), 32'h0);
        check("mid_ch0", ch_a[31:0], 32'h5);
        check("mid_cnt", 32'(cnt_a), 32'h0);

        // Reseed coincident with a step request: ACK still happens
        tick();
        reset = 1'b1;
        tick();
        check("rs_step_ch0", ch_a[31:0], 32'hA);
        tick();
        step_req = 1'b0;
        tick();
        step_req = 1'b1; reseed = 1'b1;
        tick();
        check("rs_step_ack", 32'(ack_a), 32'h1);
        check("rs_step_ch0b", ch_a[31:0], 32'h5);
        check("rs_step_cnt", 32'(cnt_a), 32'h0);
        reseed = 1'b0; step_req = 1'b0;

        // adv_cnt wrap
        reset = 1'b0; mode = 2'b00;
        tick();
        reset = 1'b1;
        repeat (65535) tick();
        check("wrap_ffff", 32'(cnt_a), 32'hFFFF);
        tick();
        check("wrap_zero", 32'(cnt_a), 32'h0);

        // MISR with obs_in = 1
        reset = 1'b0; mode = 2'b01; obs_in = 128'h1;
        tick();
        check("misr_rst", sig_a, 32'h0);
        reset = 1'b1;
        tick();
        check("misr1", sig_a, misr_on ? 32'h1 : 32'h0);
        tick();
        check("misr2", sig_a, misr_on ? 32'h3 : 32'h0);
        tick();
        check("misr3", sig_a, misr_on ? 32'h7 : 32'h0);
        enable = 1'b0;
        tick();
        check("misr_hold", sig_a, misr_on ? 32'h7 : 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
